// File: rtl/apb_master_arbiter_pkg.sv
// ============================================================================
// Module : apb_arb_pkg
// Brief  : Shared types and constants for the two-requester APB master arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int NUM_REQ        = 2;
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
// ============================================================================
// Module : apb_master_arbiter_if
// Brief  : APB bus bundle with master and slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface apb_master_arbiter_if #(
  parameter int ADDR_W = apb_arb_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = apb_arb_pkg::DEFAULT_DATA_W
);

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

`default_nettype wire

// File: rtl/apb_master_arbiter_rr.sv
// ============================================================================
// Module : apb_rr_arbiter
// Brief  : Two-way round-robin picker with a last-grant pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_grant_en,
  output logic               o_valid,
  output logic               o_idx
);

  logic last_q;
  logic last_d;

  always_comb begin
    o_valid = |i_req;
    o_idx   = 1'b0;
    if (i_req == '1) begin
      o_idx = ~last_q;
    end else begin
      o_idx = i_req[1];
    end
    last_d = last_q;
    if (i_grant_en && o_valid) begin
      last_d = o_idx;
    end
  end

  // Reset value marks requester 1 as last winner so requester 0 is favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// Module : apb_master_arbiter
// Brief  : Arbitrates two requesters onto one APB master port (IDLE/SETUP/ACCESS).
//          Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  apb_master_arbiter_if.master           apb
);

  apb_state_e          state_q, state_d;
  logic                idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0]  w_arb_req;
  logic                w_arb_valid;
  logic                w_arb_idx;
  logic                w_grant_en;

  // The requester being acked this cycle is still holding req; keep it out.
  assign w_arb_req  = req & ~ack_q;
  assign w_grant_en = (state_q == IDLE);

  apb_rr_arbiter u_rr (
    .clk        (PCLK),
    .rst        (PRESET),
    .i_req      (w_arb_req),
    .i_grant_en (w_grant_en),
    .o_valid    (w_arb_valid),
    .o_idx      (w_arb_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = '0;
    err_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_arb_valid) begin
          idx_d   = w_arb_idx;
          addr_d  = req_addr[w_arb_idx];
          write_d = req_write[w_arb_idx];
          wdata_d = req_wdata[w_arb_idx];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (apb.PREADY) begin
          state_d       = IDLE;
          ack_d[idx_q]  = 1'b1;
          rdata_d       = write_q ? '0 : apb.PRDATA;
          err_d         = apb.PSLVERR;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          ack_d[idx_q] = 1'b1;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign apb.PSEL    = (state_q != IDLE);
  assign apb.PENABLE = (state_q == ACCESS);
  assign apb.PADDR   = addr_q;
  assign apb.PWRITE  = write_q;
  assign apb.PWDATA  = wdata_q;
  assign ack         = ack_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// Module : tb_apb_master_arbiter
// Brief  : Self-checking bench: directed scenarios plus randomized traffic
//          compared every cycle against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic                       PCLK = 1'b0;
  logic                       PRESET;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0][AW-1:0] req_addr;
  logic [NUM_REQ-1:0]         req_write;
  logic [NUM_REQ-1:0][DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]         ack;
  logic [DW-1:0]              rsp_rdata;
  logic                       rsp_err;

  apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req       (req),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transfer with an age counter
  // (age 1 = setup cycle, age >= 2 = access cycles).
  bit              m_valid = 1'b0;
  bit              m_busy;
  int              m_who, m_age, m_last;
  logic [AW-1:0]   m_addr;
  logic            m_write;
  logic [DW-1:0]   m_wdata;
  logic [1:0]      m_ack, m_prev, m_elig;
  logic [DW-1:0]   m_rdata;
  logic            m_err;

  initial forever begin
    @(posedge PCLK);
    if (PRESET) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_who   = 0;
      m_age   = 0;
      m_last  = 1;
      m_addr  = '0;
      m_write = 1'b0;
      m_wdata = '0;
      m_ack   = '0;
      m_rdata = '0;
      m_err   = 1'b0;
    end else if (m_valid) begin
      m_prev  = m_ack;
      m_ack   = '0;
      m_rdata = '0;
      m_err   = 1'b0;
      if (m_busy) begin
        if (m_age == 1) begin
          m_age = 2;
        end else if (apb.PREADY) begin
          m_busy       = 1'b0;
          m_ack[m_who] = 1'b1;
          m_rdata      = m_write ? '0 : apb.PRDATA;
          m_err        = apb.PSLVERR;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (m_age - 1 == TMO) begin
          m_busy       = 1'b0;
          m_ack[m_who] = 1'b1;
          m_err        = 1'b1;
        end
`endif
        else begin
          m_age++;
        end
      end else begin
        m_elig = req & ~m_prev;
        if (m_elig != 2'b00) begin
          m_who   = (m_elig == 2'b11) ? 1 - m_last : (m_elig[1] ? 1 : 0);
          m_last  = m_who;
          m_busy  = 1'b1;
          m_age   = 1;
          m_addr  = req_addr[m_who];
          m_write = req_write[m_who];
          m_wdata = req_wdata[m_who];
        end
      end
    end
  end

  initial forever begin
    @(negedge PCLK);
    if (m_valid) begin
      chk("psel",      apb.PSEL,    m_busy);
      chk("penable",   apb.PENABLE, m_busy && m_age >= 2);
      chk("paddr",     apb.PADDR,   m_addr);
      chk("pwrite",    apb.PWRITE,  m_write);
      chk("pwdata",    apb.PWDATA,  m_wdata);
      chk("ack",       ack,         m_ack);
      chk("rsp_rdata", rsp_rdata,   m_rdata);
      chk("rsp_err",   rsp_err,     m_err);
    end
  end

  task automatic step();
    @(negedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req[i]       = 1'b1;
    req_addr[i]  = a;
    req_write[i] = w;
    req_wdata[i] = d;
  endtask

  int stall = 0;

  initial begin
    PRESET      = 1'b1;
    req         = '0;
    req_addr    = '0;
    req_write   = '0;
    req_wdata   = '0;
    apb.PREADY  = 1'b1;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    repeat (3) step();
    chk("rst_psel",    apb.PSEL,    1'b0);
    chk("rst_penable", apb.PENABLE, 1'b0);
    chk("rst_paddr",   apb.PADDR,   '0);
    chk("rst_ack",     ack,         2'b00);
    chk("rst_rdata",   rsp_rdata,   '0);
    PRESET = 1'b0;
    step();

    // Single write, zero wait states.
    set_req(0, 32'h10, 1'b1, 32'hA5A5_0001);
    step(); chk("w_c1_psel", apb.PSEL, 1'b1); chk("w_c1_pen", apb.PENABLE, 1'b0);
    chk("w_c1_paddr", apb.PADDR, 32'h10);
    step(); chk("w_c2_pen", apb.PENABLE, 1'b1); chk("w_c2_pwdata", apb.PWDATA, 32'hA5A5_0001);
    step(); chk("w_c3_ack", ack, 2'b01); chk("w_c3_err", rsp_err, 1'b0);
    chk("w_c3_rdata", rsp_rdata, '0);
    req[0] = 1'b0;
    step();

    // Read on requester 1 with three wait states.
    set_req(1, 32'h20, 1'b0, '0);
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h1234_5678;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("r_paddr", apb.PADDR, 32'h20);
      chk("r_ack_early", ack, 2'b00);
      if (c == 5) begin
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'hDEAD_BEEF;
      end
    end
    step(); chk("r_c6_ack", ack, 2'b10); chk("r_c6_rdata", rsp_rdata, 32'hDEAD_BEEF);
    req[1] = 1'b0;
    apb.PRDATA = 32'h0BAD_0BAD;
    step();

    // Slave error.
    set_req(0, 32'h30, 1'b0, '0);
    apb.PSLVERR = 1'b1;
    repeat (3) step();
    chk("e_ack", ack, 2'b01); chk("e_err", rsp_err, 1'b1);
    req[0] = 1'b0;
    apb.PSLVERR = 1'b0;
    step();

    // Reset during an ACCESS wait state; requester 0 must win afterwards.
    set_req(0, 32'h40, 1'b1, 32'h44);
    apb.PREADY = 1'b0;
    step(); step();
    PRESET = 1'b1;
    set_req(1, 32'h50, 1'b0, '0);
    step(); chk("rm_psel", apb.PSEL, 1'b0); chk("rm_ack", ack, 2'b00);
    PRESET = 1'b0;
    step(); chk("rm_regrant_psel", apb.PSEL, 1'b1); chk("rm_regrant_paddr", apb.PADDR, 32'h40);
    apb.PREADY = 1'b1;
    step(); step(); chk("rm_ack0", ack, 2'b01);
    req[0] = 1'b0;
    step(); chk("rm_next_paddr", apb.PADDR, 32'h50);
    step(); step(); chk("rm_ack1", ack, 2'b10);
    req[1] = 1'b0;
    step();

    // Continuous contention: order 0,1,0,1 with one IDLE/ack cycle between.
    set_req(0, 32'h60, 1'b1, 32'h600);
    set_req(1, 32'h70, 1'b1, 32'h700);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("cont_ack", ack, (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b01 : 2'b10));
      chk("cont_psel", apb.PSEL, (c % 3) != 0);
    end
    req = '0;
    step(); step();

`ifdef APB_ARB_TIMEOUT_EN
    set_req(0, 32'h80, 1'b0, '0);
    apb.PREADY = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("to_ack_early", ack, 2'b00);
    end
    step(); chk("to_ack", ack, 2'b01); chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, '0); chk("to_psel", apb.PSEL, 1'b0);
    req[0] = 1'b0;
    step(); chk("to_idle", apb.PSEL, 1'b0);
    apb.PREADY = 1'b1;
    step();
`endif

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      step();
      PRESET = ($urandom % 200) == 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom % 3 == 0) set_req(i, $urandom, 1'($urandom % 2), $urandom);
        end else if ($urandom % 4 == 0) begin
          req_addr[i]  = $urandom;
          req_wdata[i] = $urandom;
        end
      end
      if (stall == 0 && $urandom % 60 == 0) stall = 20;
      if (stall > 0) begin
        apb.PREADY = 1'b0;
        stall--;
      end else begin
        apb.PREADY = ($urandom % 3) != 0;
      end
      apb.PRDATA  = $urandom;
      apb.PSLVERR = ($urandom % 6) == 0;
    end
    PRESET = 1'b0;
    req    = '0;
    apb.PREADY = 1'b1;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the PADDR port and of each req_addr slot.
REQ-002 Parameter DATA_W, default 32, width of the PWDATA/PRDATA ports, each req_wdata slot and rsp_rdata.
REQ-003 Parameter TIMEOUT, default 16, maximum number of ACCESS cycles with PREADY low; used only when APB_ARB_TIMEOUT_EN is defined.
REQ-004 Port PCLK  input  1  single clock; all logic samples on its rising edge.
REQ-005 Port PRESET  input  1  synchronous, active-high reset.
REQ-006 Port req  input  2  per-requester transfer request, held high until that requester's ack.
REQ-007 Port req_addr  input  2xADDR_W  per-requester address.
REQ-008 Port req_write  input  2  per-requester direction, 1 = write.
REQ-009 Port req_wdata  input  2xDATA_W  per-requester write data.
REQ-010 Port ack  output  2  one-cycle completion pulse for the granted requester.
REQ-011 Port rsp_rdata  output  DATA_W  read data, valid while ack is high.
REQ-012 Port rsp_err  output  1  transfer error, valid while ack is high.
REQ-013 Ports PADDR (ADDR_W), PSEL, PENABLE, PWRITE, PWDATA (DATA_W) are outputs; PRDATA (DATA_W), PREADY, PSLVERR are inputs; all carry standard APB meaning.

Function
REQ-014 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-015 In IDLE with any unmasked req high, the block SHALL grant one requester, latch its addr/write/wdata, and enter SETUP on the next edge.
REQ-016 Arbitration SHALL be round-robin: on contention, the requester not granted last wins; after reset, requester 0 wins.
REQ-017 SETUP SHALL drive PSEL=1, PENABLE=0 and SHALL go to ACCESS unconditionally.
REQ-018 ACCESS SHALL drive PSEL=1, PENABLE=1 and SHALL wait until PREADY=1, then return to IDLE.
REQ-019 PADDR, PWRITE and PWDATA SHALL hold their latched values from SETUP through the last ACCESS cycle.
REQ-020 On completion, ack[grant] SHALL be high in the following IDLE cycle only, with rsp_rdata = PRDATA for reads and 0 for writes, and rsp_err = PSLVERR.
REQ-021 Latency: req sampled in cycle 0 -> SETUP in cycle 1 -> ACCESS in cycle 2 -> ack in cycle 3 if PREADY=1 in cycle 2; each PREADY-low cycle adds one cycle.
REQ-022 The requester being acked SHALL be masked from arbitration in the ack cycle; the requester SHALL drop req on the edge after ack.
REQ-023 Changes on req* inputs during SETUP or ACCESS SHALL be ignored.
REQ-024 PRDATA and PSLVERR SHALL be sampled only in the ACCESS cycle where PREADY=1.

Reset
REQ-025 While PRESET=1, the FSM SHALL go to IDLE and all outputs SHALL be 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack, rsp_rdata, rsp_err), and the round-robin pointer SHALL favour requester 0.
REQ-026 If reset is asserted mid-transfer, the transfer SHALL be abandoned with no ack, and PSEL/PENABLE SHALL be low on the next edge.

Configuration
REQ-027 With APB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0; when the count reaches TIMEOUT, the block SHALL abort to IDLE and pulse ack with rsp_err=1 and rsp_rdata=0.
REQ-028 Without APB_ARB_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-029 Package apb_arb_pkg SHALL hold the apb_state_e enum (IDLE, SETUP, ACCESS), the NUM_REQ=2 constant, and the default ADDR_W/DATA_W constants.
REQ-030 Round-robin grant logic SHALL be a sub-module, apb_rr_arbiter (2-way, with last-grant pointer); everything else SHALL be in apb_master_arbiter.

Verification
REQ-031 Single write: req[0] with addr 0x10, wdata 0xA5A5_0001, PREADY tied 1 -> PSEL in cycle 1, PENABLE in cycle 2, ack=2'b01 in cycle 3, rsp_err=0.
REQ-032 Read with wait states: req[1] read at 0x20, PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> ack=2'b10 in cycle 6 with rsp_rdata=0xDEAD_BEEF and PADDR stable throughout.
REQ-033 Contention: both req high continuously for 4 transfers -> grant order 0,1,0,1 with no idle gap beyond the one IDLE/ack cycle per transfer.
REQ-034 Slave error: PSLVERR=1 with PREADY=1 -> ack with rsp_err=1.
REQ-035 Reset mid-ACCESS: PRESET pulsed for one cycle during a wait state -> PSEL=0 on the next edge, no ack, and requester 0 wins the next arbitration.
REQ-036 With APB_ARB_TIMEOUT_EN and TIMEOUT=16: PREADY held 0 -> ack with rsp_err=1 after 16 ACCESS cycles, then back to IDLE.
